// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operands/op select in, result/flags out.
// The master modport is the issuing side, the slave modport is the adder.
interface pipe_adder_if #(
   parameter int WIDTH = 32
);

   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             sub;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] rAdd;
   logic             carryOut;
   logic             overflow;

   modport master (
      output inValid, dataA, dataB, sub, outReady,
      input  inReady, outValid, rAdd, carryOut, overflow
   );

   modport slave (
      input  inValid, dataA, dataB, sub, outReady,
      output inReady, outValid, rAdd, carryOut, overflow
   );

endinterface

// File: rtl/pipe_adder.sv
// Skewed-pipeline adder/subtractor: one CW-bit chunk resolved per stage, carry registered between stages.
// Optional saturation of signed overflow is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic        clk,
   input logic        reset,
   pipe_adder_if.slave bus
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             regV [STAGES];
   logic [WIDTH-1:0] regA [STAGES];
   logic [WIDTH-1:0] regB [STAGES];
   logic [WIDTH-1:0] regR [STAGES];
   logic             regC [STAGES];
   logic             regOvf;

   logic             stV   [STAGES];
   logic [WIDTH-1:0] stA   [STAGES];
   logic [WIDTH-1:0] stB   [STAGES];
   logic [WIDTH-1:0] stR   [STAGES];
   logic             stC   [STAGES];
   logic [WIDTH-1:0] nextR [STAGES];
   logic             nextC [STAGES];

   logic             stall;
   logic             lastOvf;
   logic [WIDTH-1:0] lastR;

   // A full output register that nobody takes freezes the whole pipe.
   assign stall       = regV[LAST] & ~bus.outReady;
   assign bus.inReady = ~stall;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : gStage
         logic [CW:0]      chunkSum;
         logic [WIDTH-1:0] merged;

         if (k == 0) begin : gFirst
            assign stV[k] = bus.inValid & ~stall;
            assign stA[k] = bus.dataA;
            assign stB[k] = bus.sub ? ~bus.dataB : bus.dataB;
            assign stR[k] = '0;
            assign stC[k] = bus.sub;
         end else begin : gNext
            assign stV[k] = regV[k-1];
            assign stA[k] = regA[k-1];
            assign stB[k] = regB[k-1];
            assign stR[k] = regR[k-1];
            assign stC[k] = regC[k-1];
         end

         assign chunkSum = {1'b0, stA[k][k*CW +: CW]}
                         + {1'b0, stB[k][k*CW +: CW]}
                         + {{CW{1'b0}}, stC[k]};

         always_comb begin
            merged              = stR[k];
            merged[k*CW +: CW]  = chunkSum[CW-1:0];
         end

         assign nextR[k] = merged;
         assign nextC[k] = chunkSum[CW];
      end
   endgenerate

   // Signed overflow: operands agree in sign but the result does not.
   assign lastOvf = (stA[LAST][WIDTH-1] == stB[LAST][WIDTH-1]) &&
                    (nextR[LAST][WIDTH-1] != stA[LAST][WIDTH-1]);

`ifdef PIPE_ADDER_SAT_EN
   always_comb begin
      lastR = nextR[LAST];
      if (lastOvf) begin
         lastR = stA[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign lastR = nextR[LAST];
`endif

   // Every stage advances together unless stalled; payload only loads with a live token.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            regV[i] <= 1'b0;
            regA[i] <= '0;
            regB[i] <= '0;
            regR[i] <= '0;
            regC[i] <= 1'b0;
         end
         regOvf <= 1'b0;
      end else if (!stall) begin
         for (int i = 0; i < STAGES; i++) begin
            regV[i] <= stV[i];
            if (stV[i]) begin
               regA[i] <= stA[i];
               regB[i] <= stB[i];
               regR[i] <= (i == LAST) ? lastR : nextR[i];
               regC[i] <= nextC[i];
            end
         end
         if (stV[LAST]) begin
            regOvf <= lastOvf;
         end
      end
   end

   assign bus.outValid = regV[LAST];
   assign bus.rAdd     = regR[LAST];
   assign bus.carryOut = regC[LAST];
   assign bus.overflow = regOvf;

endmodule
